leaf_inject_arbiter: RTL and testbench

- Shares one leaf bus interface's injection port among NUM_REQ local requesters (PE output streams) using round-robin arbitration.
- Holds the granted packet on pe_interface until the interface reports a free slot (resend low), then advances. Sustains one packet per cycle.
- Sits between the PE-side stream sources and the leaf interface's pe_interface/resend pair.
- Provides per-block injection and backpressure statistics.

---
 rtl/leaf_bus_pkg.sv | 68 ++++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/leaf_inject_arbiter.sv | 155 +++++++++++++++
 tb/tb_leaf_inject_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leaf_bus_pkg
// Description : Shared packet geometry helpers for the leaf bus.
//               A packet is {valid, addr, payload}, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
package leaf_bus_pkg;

    // Default bus geometry: 2 leaves, 1 payload bit
    localparam int c_def_num_leaves = 2;
    localparam int c_def_payload_sz = 1;

    // Width of the leaf address field
    function automatic int addr_width(input int num_leaves);
        return $clog2(num_leaves);
    endfunction

    // Full packet width including the valid bit
    function automatic int pkt_width(input int num_leaves, input int payload_sz);
        return 1 + $clog2(num_leaves) + payload_sz;
    endfunction

    // Bit position of the valid flag for a packet of width p_sz
    function automatic int valid_idx(input int p_sz);
        return p_sz - 1;
    endfunction

    // Upper bound of the address field for a packet of width p_sz
    function automatic int addr_hi(input int p_sz);
        return p_sz - 2;
    endfunction

    // Lower bound of the address field; the payload sits below it
    function automatic int addr_lo(input int payload_sz);
        return payload_sz;
    endfunction

    // Field bounds for the default geometry
    localparam int c_def_addr_w    = addr_width(c_def_num_leaves);
    localparam int c_def_p_sz      = pkt_width(c_def_num_leaves, c_def_payload_sz);
    localparam int c_def_valid_idx = valid_idx(c_def_p_sz);
    localparam int c_def_addr_hi   = addr_hi(c_def_p_sz);
    localparam int c_def_addr_lo   = addr_lo(c_def_payload_sz);

    // Widest packet the packing helper can build
    localparam int c_max_pkt_w = 64;

    // Build {1'b1, addr, payload} in the low bits of a 64-bit word
    function automatic logic [c_max_pkt_w-1:0] pack_pkt(
        input logic [31:0] addr,
        input logic [31:0] payload,
        input int          addr_w,
        input int          payload_sz
    );
        logic [c_max_pkt_w-1:0] v_pkt;
        logic [c_max_pkt_w-1:0] v_amask;
        logic [c_max_pkt_w-1:0] v_pmask;
        v_pmask = (64'd1 << payload_sz) - 64'd1;
        v_amask = (64'd1 << addr_w) - 64'd1;
        v_pkt   = {32'd0, payload} & v_pmask;
        v_pkt   = v_pkt | (({32'd0, addr} & v_amask) << payload_sz);
        v_pkt   = v_pkt | (64'd1 << (addr_w + payload_sz));
        return v_pkt;
    endfunction

endpackage : leaf_bus_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request at or above ptr, wrapping at NUM_REQ. Grant is
//               one-hot and only issued while en is high.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    // Requester index visited at search offset off, starting from ptr
    function automatic int rot_idx(input logic [PTR_W-1:0] p, input int off);
        return (int'(p) + off) % NUM_REQ;
    endfunction

    // Walk requesters from ptr upward and take the first one that is valid
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !grant_any && req[rot_idx(ptr, i)]) begin
                grant[rot_idx(ptr, i)] = 1'b1;
                grant_idx              = PTR_W'(rot_idx(ptr, i));
                grant_any              = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/leaf_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : leaf_inject_arbiter
// Description : Shares one leaf interface injection port among NUM_REQ
//               local requesters. Round-robin grant, a single hold register
//               that stays put while the leaf interface reports resend, and
//               injection / backpressure statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_inject_arbiter
    import leaf_bus_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_LEAVES  = 2,
    parameter int PAYLOAD_SZ  = 1,
    parameter int P_SZ        = pkt_width(NUM_LEAVES, PAYLOAD_SZ),
    parameter int STALL_LIMIT = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*P_SZ-1:0] req_pkt,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [P_SZ-1:0]         pe_interface,
    input  logic                    resend,
    output logic                    stall,
    output logic [15:0]             sent_cnt
);

    localparam int c_ptr_w     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_bc_w      = $clog2(STALL_LIMIT + 1);
    localparam int c_valid_idx = valid_idx(P_SZ);

    localparam logic [c_bc_w-1:0]  c_stall_lim  = c_bc_w'(STALL_LIMIT);
    localparam logic [c_ptr_w-1:0] c_last_req   = c_ptr_w'(NUM_REQ - 1);
    localparam logic [P_SZ-1:0]    c_valid_mask = P_SZ'(1) << c_valid_idx;

    // Registered state
    logic                r_hold_valid;
    logic [P_SZ-1:0]     r_pe;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [c_bc_w-1:0]   r_block_cnt;
    logic                r_stall;
    logic [15:0]         r_sent_cnt;

    // Combinational
    logic                w_taken;
    logic                w_load_ok;
    logic [NUM_REQ-1:0]  w_grant;
    logic [c_ptr_w-1:0]  w_grant_idx;
    logic                w_grant_any;
    logic [P_SZ-1:0]     w_req_pkt [NUM_REQ];
    logic [P_SZ-1:0]     w_sel_pkt;
    logic [c_ptr_w-1:0]  w_rr_ptr_nxt;
    logic [c_bc_w-1:0]   w_block_cnt_nxt;

    // The leaf interface captures pe_interface on any cycle resend is low
    assign w_taken   = r_hold_valid & ~resend;
    // The hold register can accept a new packet when empty or draining now
    assign w_load_ok = ~r_hold_valid | w_taken;

    // Slice the flat packet bus into one word per requester
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_pkt[gi] = req_pkt[gi*P_SZ +: P_SZ];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .en        (w_load_ok),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    // Grant depends only on state, req_valid and resend; never on packet data
    assign req_ready = w_grant;

    // One-hot mux of the granted requester's packet
    always_comb begin
        w_sel_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_pkt = w_sel_pkt | w_req_pkt[i];
            end
        end
    end

    // Pointer moves to the requester just after the winner
    assign w_rr_ptr_nxt = (w_grant_idx == c_last_req) ? '0
                                                      : w_grant_idx + c_ptr_w'(1);

    // Blocked-cycle counter: clears when empty or taken, saturates at the limit
    always_comb begin
        w_block_cnt_nxt = r_block_cnt;
        if (!r_hold_valid || !resend) begin
            w_block_cnt_nxt = '0;
        end else if (r_block_cnt != c_stall_lim) begin
            w_block_cnt_nxt = r_block_cnt + c_bc_w'(1);
        end
    end

    // Hold register: load on grant, drain to zero on take without a grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_valid <= 1'b0;
            r_pe         <= '0;
        end else if (w_grant_any) begin
            // The requester's own MSB is replaced by a forced valid bit
            r_hold_valid <= 1'b1;
            r_pe         <= w_sel_pkt | c_valid_mask;
        end else if (w_taken) begin
            r_hold_valid <= 1'b0;
            r_pe         <= '0;
        end
    end

    // Round-robin pointer advances only on an actual grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Injected-packet counter, wraps at 2^16
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sent_cnt <= '0;
        end else if (w_taken) begin
            r_sent_cnt <= r_sent_cnt + 16'd1;
        end
    end

    // Backpressure tracking and the registered stall flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_block_cnt <= '0;
            r_stall     <= 1'b0;
        end else begin
            r_block_cnt <= w_block_cnt_nxt;
            r_stall     <= (w_block_cnt_nxt == c_stall_lim);
        end
    end

    assign pe_interface = r_pe;
    assign stall        = r_stall;
    assign sent_cnt     = r_sent_cnt;

endmodule : leaf_inject_arbiter
`default_nettype wire

// File: tb/tb_leaf_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_inject_arbiter
// Description : Directed scoreboard bench for leaf_inject_arbiter with
//               4 requesters, 4 leaves, 8-bit payload, stall limit 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_inject_arbiter;

    localparam int c_nreq = 4;
    localparam int c_psz  = 11;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [c_nreq-1:0]        req_valid = '0;
    logic [c_nreq*c_psz-1:0]  req_pkt = '0;
    logic [c_nreq-1:0]        req_ready;
    logic [c_psz-1:0]         pe_interface;
    logic                     resend = 1'b0;
    logic                     stall;
    logic [15:0]              sent_cnt;

    int checks   = 0;
    int failures = 0;

    logic [c_psz-1:0] sb [$];

    logic [3:0]       rr_order [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [c_psz-1:0] exp_rr   [4] = '{11'h410, 11'h511, 11'h612, 11'h713};

    leaf_inject_arbiter #(
        .NUM_REQ     (4),
        .NUM_LEAVES  (4),
        .PAYLOAD_SZ  (8),
        .P_SZ        (11),
        .STALL_LIMIT (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_pkt      (req_pkt),
        .req_ready    (req_ready),
        .pe_interface (pe_interface),
        .resend       (resend),
        .stall        (stall),
        .sent_cnt     (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse spanning one edge; pending expectations are discarded
    task automatic pulse_reset();
        req_valid = '0;
        resend    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        step();
        reset_n = 1'b1;
    endtask

    // Monitor: every packet the leaf interface takes must match the queue head
    always @(negedge clk) begin
        if (reset_n && pe_interface[c_psz-1] && !resend) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got %h expected none at %0t", pe_interface, $time);
            end else begin
                logic [c_psz-1:0] e;
                e = sb.pop_front();
                if (pe_interface !== e) begin
                    failures++;
                    $display("FAIL sb_pkt: got %h expected %h at %0t", pe_interface, e, $time);
                end
            end
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_pe",    32'(pe_interface), 32'h0);
        chk("rst_cnt",   32'(sent_cnt),     32'h0);
        chk("rst_stall", 32'(stall),        32'h0);
        chk("rst_ready", 32'(req_ready),    32'h0);
        step();
        step();
        reset_n = 1'b1;

        // Single requester; resend is ignored while the hold register is empty
        req_valid = 4'b0001;
        req_pkt   = {33'd0, 11'h0A5};
        resend    = 1'b1;
        #1 chk("single_ready", 32'(req_ready), 32'h1);
        sb.push_back(11'h4A5);
        step();
        req_valid = '0;
        resend    = 1'b0;
        #1 chk("single_pe", 32'(pe_interface), 32'h4A5);
        chk("single_ready_off", 32'(req_ready), 32'h0);
        step();
        chk("single_drain", 32'(pe_interface), 32'h0);
        chk("single_cnt",   32'(sent_cnt),     32'h1);

        // Reset mid-operation while a packet is blocked
        req_valid = 4'b0010;
        req_pkt   = {22'd0, 11'h1C3, 11'h000};
        #1 chk("rstmid_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        resend    = 1'b1;
        #1 chk("rstmid_held", 32'(pe_interface), 32'h5C3);
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_pe",    32'(pe_interface), 32'h0);
        chk("rstmid_cnt",   32'(sent_cnt),     32'h0);
        chk("rstmid_stall", 32'(stall),        32'h0);
        step();
        reset_n = 1'b1;
        resend  = 1'b0;
        step();
        chk("rstmid_gone", 32'(pe_interface), 32'h0);

        // Round-robin fairness: all four valid, one grant per cycle
        pulse_reset();
        req_pkt   = {11'h313, 11'h612, 11'h111, 11'h010};
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_ready", 32'(req_ready), 32'(rr_order[k % 4]));
            sb.push_back(exp_rr[k % 4]);
            step();
        end
        req_valid = '0;
        #1 chk("rr_last_pe", 32'(pe_interface), 32'h713);
        step();
        chk("rr_cnt",   32'(sent_cnt),     32'd8);
        chk("rr_drain", 32'(pe_interface), 32'h0);

        // Backpressure: 5 blocked cycles, stall, then take with same-cycle load
        pulse_reset();
        req_pkt   = {22'd0, 11'h0CD, 11'h2AB};
        req_valid = 4'b0001;
        #1 chk("bp_ready0", 32'(req_ready), 32'h1);
        sb.push_back(11'h6AB);
        step();
        for (int b = 1; b <= 5; b++) begin
            req_valid = 4'b0010;
            resend    = 1'b1;
            #1;
            chk("bp_ready_blk", 32'(req_ready),    32'h0);
            chk("bp_pe_blk",    32'(pe_interface), 32'h6AB);
            chk("bp_stall_blk", 32'(stall),        (b == 5) ? 32'h1 : 32'h0);
            step();
        end
        resend = 1'b0;
        #1 chk("bp_ready_take", 32'(req_ready), 32'h2);
        chk("bp_stall_take", 32'(stall), 32'h1);
        sb.push_back(11'h4CD);
        step();
        req_valid = '0;
        #1 chk("bp_pe_next", 32'(pe_interface), 32'h4CD);
        chk("bp_stall_clr", 32'(stall), 32'h0);
        step();
        chk("bp_drain", 32'(pe_interface), 32'h0);

        // Simultaneous take and load with the pointer at 2
        pulse_reset();
        req_pkt   = {11'h377, 11'h000, 11'h155, 11'h0EE};
        req_valid = 4'b0010;
        #1 chk("tl_ready1", 32'(req_ready), 32'h2);
        sb.push_back(11'h555);
        step();
        req_valid = 4'b1001;
        #1 chk("tl_ready3", 32'(req_ready), 32'h8);
        sb.push_back(11'h777);
        step();
        req_valid = 4'b0001;
        #1 chk("tl_pe3",    32'(pe_interface), 32'h777);
        chk("tl_ready0", 32'(req_ready), 32'h1);
        sb.push_back(11'h4EE);
        step();
        req_valid = '0;
        #1 chk("tl_pe0", 32'(pe_interface), 32'h4EE);
        step();
        chk("tl_drain", 32'(pe_interface), 32'h0);
        chk("tl_cnt",   32'(sent_cnt),     32'd3);

        // Counter wrap after 65536 injected packets
        pulse_reset();
        req_pkt   = {33'd0, 11'h3FF};
        req_valid = 4'b0001;
        for (int k = 0; k < 65536; k++) begin
            sb.push_back(11'h7FF);
            step();
        end
        req_valid = '0;
        chk("wrap_ffff", 32'(sent_cnt), 32'h0000FFFF);
        step();
        chk("wrap_zero", 32'(sent_cnt),     32'h0);
        chk("wrap_pe",   32'(pe_interface), 32'h0);

        step();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_leaf_inject_arbiter
`default_nettype wire
